conv_encoder_serial: RTL and testbench

//  802.11a-style K=7 convolutional encoder (g0=133o, g1=171o) with puncturing.

---
 rtl/wlan_tx_pkg.sv | 48 ++++
 rtl/conv_core.sv | 42 ++++
 rtl/conv_encoder_serial.sv | 159 +++++++++++++++
 tb/tb_conv_encoder_serial.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wlan_tx_pkg.sv
// Shared types, constants and puncturing helpers for the 802.11a transmit
// convolutional encoder.
package wlan_tx_pkg;

  localparam int N_CBPS = 48;               // coded bits per OFDM symbol
  localparam int K      = 7;                // constraint length
  localparam int SYM_W  = $clog2(N_CBPS);   // symbol counter width
  localparam int TAIL_W = $clog2(K);        // counts 0..K-1 tail bits

  // Generator polynomials, MSB taps the new data bit, LSB the oldest state bit.
  localparam logic [K-1:0] G0 = 7'o133;
  localparam logic [K-1:0] G1 = 7'o171;

  typedef enum logic [1:0] {RATE_1_2, RATE_2_3, RATE_3_4} rate_e;
  typedef enum logic [1:0] {IDLE, RUN, TAIL, PAD} state_e;

  // Reserved code 3 falls back to rate 1/2.
  function automatic rate_e rate_decode(input logic [1:0] code);
    case (code)
      2'd1:    return RATE_2_3;
      2'd2:    return RATE_3_4;
      default: return RATE_1_2;
    endcase
  endfunction

  // Last puncture phase of a data-bit group: 1/2 -> 1, 2/3 -> 2, 3/4 -> 3.
  function automatic logic [1:0] phase_last(input rate_e rate);
    case (rate)
      RATE_2_3: return 2'd2;
      RATE_3_4: return 2'd3;
      default:  return 2'd1;
    endcase
  endfunction

  // Phases that start a kept A/B pair and therefore pull in a new data bit.
  // 1/2: A0 B0   2/3: A0 B0 A1   3/4: A0 B0 A1 B2
  function automatic logic phase_consumes(input rate_e rate, input logic [1:0] phase);
    return (phase == 2'd0)
        || (phase == 2'd2 && rate != RATE_1_2)
        || (phase == 2'd3 && rate == RATE_3_4);
  endfunction

  // Phases whose emitted bit is the B output rather than A.
  function automatic logic phase_emits_b(input rate_e rate, input logic [1:0] phase);
    return (phase == 2'd1) || (phase == 2'd3 && rate == RATE_3_4);
  endfunction

endpackage

// File: rtl/conv_core.sv
// K=7 convolutional core: 6-bit history shift register and the two generator
// XOR trees. A/B are combinational from the incoming bit and current history.
module conv_core
  import wlan_tx_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic clr_i,
  input  logic load_i,
  input  logic d_i,
  output logic a_o,
  output logic b_o
);

  logic [K-2:0] s_q;    // s_q[0] = previous bit ... s_q[K-2] = oldest
  logic [K-1:0] taps;

  // Arrange {d, s[0], ..., s[5]} so bit positions line up with the octal generators.
  always_comb begin
    taps      = '0;
    taps[K-1] = d_i;
    for (int i = 0; i < K - 1; i++) begin
      taps[K-2-i] = s_q[i];
    end
  end

  assign a_o = ^(taps & G0);
  assign b_o = ^(taps & G1);

  // History register: cleared at frame start, shifts once per consumed bit.
  always_ff @(posedge Clock or posedge Reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      s_q <= '0;
    end else if (clr_i) begin
      s_q <= '0;
    end else if (load_i) begin
      s_q <= {s_q[K-3:0], d_i};
    end
  end

endmodule

// File: rtl/conv_encoder_serial.sv
// Serial punctured convolutional encoder feeding the 48-bit block interleaver.
// Emits one coded bit per clock for the whole frame, substituting zero data on
// starvation, appending six tail zeros after Flush and padding to a symbol end.
module conv_encoder_serial
  import wlan_tx_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] Rate,
  input  logic       InBit,
  input  logic       InValid,
  output logic       InReady,
  input  logic       Flush,
  output logic       Output,
  output logic       OutValid,
  output logic       SymEnd,
  output logic       Busy,
  output logic       Underrun
);

  localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(N_CBPS - 1);
  localparam logic [TAIL_W-1:0] TAIL_BITS = TAIL_W'(K - 1);

  state_e              state_q;
  rate_e               rate_q;
  logic [1:0]          phase_q;
  logic [SYM_W-1:0]    sym_cnt_q;
  logic [TAIL_W-1:0]   tail_cnt_q;
  logic                b_q;          // B of the last consumed bit, emitted on the following phase
  logic                out_q;
  logic                out_valid_q;
  logic                sym_end_q;
  logic                in_ready_q;
  logic                busy_q;
  logic                underrun_q;

  logic                start_ok;
  logic                emitting;
  logic                consume;
  logic                starve;
  logic                core_clr;
  logic                core_load;
  logic                core_d;
  logic                core_a;
  logic                core_b;
  logic                emit_bit;
  logic                sym_last;
  logic                tail_done;
  logic [1:0]          phase_d;
  logic [SYM_W-1:0]    sym_cnt_d;
  logic [TAIL_W-1:0]   tail_cnt_d;

  conv_core u_core (
    .Clock  (Clock),
    .Reset  (Reset),
    .clr_i  (core_clr),
    .load_i (core_load),
    .d_i    (core_d),
    .a_o    (core_a),
    .b_o    (core_b)
  );

  // Per-cycle decisions: whether a data bit is consumed, which coded bit goes out,
  // and the next phase/counter values.
  always_comb begin
    // NOTE: every signal is assigned unconditionally here so no latch can be inferred.
    // Busy still high in IDLE means the last bit is on Output; Start waits one more cycle.
    start_ok   = (state_q == IDLE) && !busy_q && Start;
    emitting   = (state_q == RUN) || (state_q == TAIL);
    consume    = emitting && phase_consumes(rate_q, phase_q);
    starve     = (state_q == RUN) && consume && !InValid;
    core_clr   = start_ok;
    core_load  = consume;
    // Starved RUN cycles and all TAIL cycles encode a zero.
    core_d     = (state_q == RUN) && InValid && InBit;
    phase_d    = (phase_q == phase_last(rate_q)) ? 2'd0 : phase_q + 2'd1;
    emit_bit   = phase_emits_b(rate_q, phase_q) ? (consume ? core_b : b_q) : core_a;
    sym_last   = (sym_cnt_q == SYM_LAST);
    sym_cnt_d  = sym_last ? '0 : sym_cnt_q + 1'b1;
    tail_cnt_d = tail_cnt_q + TAIL_W'((state_q == TAIL) && consume);
    // Tail is finished once the sixth tail bit and its kept coded bits are out.
    tail_done  = (state_q == TAIL) && (tail_cnt_d == TAIL_BITS)
              && phase_consumes(rate_q, phase_d);
  end

  // Frame FSM with registered outputs; each edge describes the bit emitted on it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      rate_q      <= RATE_1_2;
      phase_q     <= 2'd0;
      sym_cnt_q   <= '0;
      tail_cnt_q  <= '0;
      b_q         <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sym_end_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_q       <= 1'b0;
          out_valid_q <= 1'b0;
          sym_end_q   <= 1'b0;
          phase_q     <= 2'd0;
          sym_cnt_q   <= '0;
          tail_cnt_q  <= '0;
          busy_q      <= start_ok;
          in_ready_q  <= start_ok;
          if (start_ok) begin
            rate_q     <= rate_decode(Rate);
            underrun_q <= 1'b0;
            state_q    <= RUN;
          end
        end

        RUN, TAIL: begin
          out_q       <= emit_bit;
          out_valid_q <= 1'b1;
          sym_end_q   <= sym_last;
          sym_cnt_q   <= sym_cnt_d;
          phase_q     <= phase_d;
          tail_cnt_q  <= tail_cnt_d;
          if (core_load) b_q <= core_b;
          if (starve) underrun_q <= 1'b1;
          // The Flush cycle itself still behaves as RUN; TAIL starts after it.
          in_ready_q  <= (state_q == RUN) && !Flush && phase_consumes(rate_q, phase_d);
          if (state_q == RUN && Flush) begin
            state_q <= TAIL;
          end else if (tail_done) begin
            state_q <= sym_last ? IDLE : PAD;
          end
        end

        PAD: begin
          out_q       <= 1'b0;
          out_valid_q <= 1'b1;
          sym_end_q   <= sym_last;
          sym_cnt_q   <= sym_cnt_d;
          in_ready_q  <= 1'b0;
          if (sym_last) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign InReady  = in_ready_q;
  assign Output   = out_q;
  assign OutValid = out_valid_q;
  assign SymEnd   = sym_end_q;
  assign Busy     = busy_q;
  assign Underrun = underrun_q;

endmodule

// File: tb/tb_conv_encoder_serial.sv
// Directed self-checking bench for conv_encoder_serial.
module tb_conv_encoder_serial;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic [1:0] Rate;
  logic       InBit;
  logic       InValid;
  logic       InReady;
  logic       Flush;
  logic       Output;
  logic       OutValid;
  logic       SymEnd;
  logic       Busy;
  logic       Underrun;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  conv_encoder_serial dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Rate     (Rate),
    .InBit    (InBit),
    .InValid  (InValid),
    .InReady  (InReady),
    .Flush    (Flush),
    .Output   (Output),
    .OutValid (OutValid),
    .SymEnd   (SymEnd),
    .Busy     (Busy),
    .Underrun (Underrun)
  );

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset;
    Reset = 1'b1; Start = 1'b0; Flush = 1'b0; InBit = 1'b0; InValid = 1'b0; Rate = 2'd0;
    tick; tick;
    Reset = 1'b0;
    tick;
  endtask

  task automatic start_frame(input logic [1:0] r);
    Rate = r; Start = 1'b1;
    tick;
    Start = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1; Start = 1'b0; Flush = 1'b0; InBit = 1'b0; InValid = 1'b0; Rate = 2'd0;
    tick; tick;
    checks++;
    if ({Output, OutValid, SymEnd, Busy, InReady, Underrun} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {Output, OutValid, SymEnd, Busy, InReady, Underrun});
    end
    Reset = 1'b0;
    tick; tick;
    checks++;
    if (Busy !== 1'b0 || OutValid !== 1'b0 || InReady !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b ov=%b rdy=%b expected 0 0 0", Busy, OutValid, InReady);
    end
  endtask

  task automatic test_impulse;
    logic [15:0] exp_out;
    logic [7:0]  data;
    int          idx;
    exp_out = 16'b11_01_11_11_00_10_11_00;
    data    = 8'b1000_0000;
    idx     = 0;
    apply_reset;
    start_frame(2'd0);
    checks++;
    if (InReady !== 1'b1 || Busy !== 1'b1 || OutValid !== 1'b0) begin
      errors++;
      $display("FAIL impulse_start: got rdy=%b busy=%b ov=%b expected 1 1 0", InReady, Busy, OutValid);
    end
    for (int k = 0; k < 16; k++) begin
      logic rdy;
      rdy = InReady;
      checks++;
      if (rdy !== ((k % 2) == 0)) begin
        errors++;
        $display("FAIL impulse_ready[%0d]: got %b expected %b", k, rdy, (k % 2) == 0);
      end
      InValid = 1'b1;
      InBit   = data[7-idx];
      tick;
      if (rdy) idx++;
      checks++;
      if (Output !== exp_out[15-k] || OutValid !== 1'b1) begin
        errors++;
        $display("FAIL impulse_out[%0d]: got %b/%b expected %b/1", k, Output, OutValid, exp_out[15-k]);
      end
    end
    InValid = 1'b0;
  endtask

  task automatic test_puncture;
    logic [1:0] rates  [3];
    logic [7:0] datas  [3];
    logic [7:0] exps   [3];
    logic [7:0] readys [3];
    int         lens   [3];
    rates  = '{2'd2, 2'd1, 2'd3};
    datas  = '{8'b1110_0000, 8'b1110_0000, 8'b1000_0000};
    exps   = '{8'b1111_0101, 8'b1110_1000, 8'b1101_1111};
    readys = '{8'b1011_1011, 8'b1011_0100, 8'b1010_1010};
    lens   = '{8, 6, 8};
    for (int i = 0; i < 3; i++) begin
      int cons;
      cons = 0;
      apply_reset;
      start_frame(rates[i]);
      for (int k = 0; k < lens[i]; k++) begin
        logic rdy;
        rdy = InReady;
        checks++;
        if (rdy !== readys[i][7-k]) begin
          errors++;
          $display("FAIL puncture_ready rate=%0d cyc=%0d: got %b expected %b", rates[i], k, rdy, readys[i][7-k]);
        end
        InValid = 1'b1;
        InBit   = (cons < 8) ? datas[i][7-cons] : 1'b0;
        tick;
        if (rdy) cons++;
        checks++;
        if (Output !== exps[i][7-k]) begin
          errors++;
          $display("FAIL puncture_out rate=%0d cyc=%0d: got %b expected %b", rates[i], k, Output, exps[i][7-k]);
        end
      end
      InValid = 1'b0;
    end
  endtask

  task automatic test_framing;
    logic [11:0] tail_pat;
    int          n_out;
    int          idx;
    logic        flushed;
    logic        done;
    tail_pat = 12'b01_11_11_00_10_11;
    n_out = 0; idx = 0; flushed = 1'b0; done = 1'b0;
    apply_reset;
    start_frame(2'd0);
    for (int c = 0; c < 300 && !done; c++) begin
      logic rdy;
      logic exp_bit;
      rdy     = InReady;
      InValid = (idx < 20);
      InBit   = (idx == 19);
      Flush   = (idx == 20) && !flushed && !rdy;
      if (Flush) flushed = 1'b1;
      tick;
      Flush = 1'b0;
      if (rdy && idx < 20) idx++;
      if (flushed) begin
        checks++;
        if (InReady !== 1'b0) begin
          errors++;
          $display("FAIL framing_ready_after_flush cyc=%0d: got %b expected 0", c, InReady);
        end
      end
      if (OutValid === 1'b1) begin
        n_out++;
        exp_bit = 1'b0;
        if (n_out == 39 || n_out == 40) exp_bit = 1'b1;
        else if (n_out >= 41 && n_out <= 52) exp_bit = tail_pat[52-n_out];
        checks++;
        if (Output !== exp_bit) begin
          errors++;
          $display("FAIL framing_out[%0d]: got %b expected %b", n_out, Output, exp_bit);
        end
        checks++;
        if (SymEnd !== (n_out == 48 || n_out == 96)) begin
          errors++;
          $display("FAIL framing_symend[%0d]: got %b expected %b", n_out, SymEnd, (n_out == 48 || n_out == 96));
        end
        checks++;
        if (Busy !== 1'b1) begin
          errors++;
          $display("FAIL framing_busy[%0d]: got %b expected 1", n_out, Busy);
        end
      end else if (n_out > 0) begin
        done = 1'b1;
        checks++;
        if (n_out != 96) begin
          errors++;
          $display("FAIL framing_length: got %0d expected 96", n_out);
        end
        checks++;
        if (Busy !== 1'b0) begin
          errors++;
          $display("FAIL framing_busy_end: got %b expected 0", Busy);
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL framing_timeout: got %0d outputs expected frame end", n_out);
    end
    checks++;
    if (Underrun !== 1'b0) begin
      errors++;
      $display("FAIL framing_underrun: got %b expected 0", Underrun);
    end
  endtask

  task automatic test_starvation;
    logic [11:0] exp_out;
    int          cons;
    exp_out = 12'b11_01_11_11_00_10;
    cons = 0;
    apply_reset;
    start_frame(2'd0);
    for (int k = 0; k < 12; k++) begin
      logic rdy;
      rdy     = InReady;
      InValid = (cons != 1);
      InBit   = (cons <= 1);
      tick;
      if (rdy) cons++;
      checks++;
      if (Output !== exp_out[11-k] || OutValid !== 1'b1) begin
        errors++;
        $display("FAIL starve_out[%0d]: got %b/%b expected %b/1", k, Output, OutValid, exp_out[11-k]);
      end
      checks++;
      if (Underrun !== (k >= 2)) begin
        errors++;
        $display("FAIL starve_underrun[%0d]: got %b expected %b", k, Underrun, k >= 2);
      end
    end
    InValid = 1'b1; InBit = 1'b0;
    tick;
    InValid = 1'b0; Flush = 1'b1;
    tick;
    Flush = 1'b0;
    for (int c = 0; c < 150 && Busy === 1'b1; c++) begin
      checks++;
      if (OutValid !== 1'b1) begin
        errors++;
        $display("FAIL starve_outvalid cyc=%0d: got %b expected 1", c, OutValid);
      end
      tick;
    end
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL starve_timeout: got busy=%b expected 0", Busy);
    end
    checks++;
    if (Underrun !== 1'b1) begin
      errors++;
      $display("FAIL starve_sticky: got %b expected 1", Underrun);
    end
    start_frame(2'd0);
    checks++;
    if (Underrun !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL starve_clear_on_start: got underrun=%b busy=%b expected 0 1", Underrun, Busy);
    end
  endtask

  task automatic test_reset_mid_tail;
    logic [3:0] exp_out;
    int         cons;
    apply_reset;
    start_frame(2'd0);
    for (int k = 0; k < 5; k++) begin
      InValid = 1'b1; InBit = 1'b1;
      tick;
    end
    InValid = 1'b0; Flush = 1'b1;
    tick;
    Flush = 1'b0;
    tick; tick;
    checks++;
    if (Output !== 1'b1 || Busy !== 1'b1 || OutValid !== 1'b1 || InReady !== 1'b0) begin
      errors++;
      $display("FAIL tail_before_reset: got out=%b busy=%b ov=%b rdy=%b expected 1 1 1 0",
               Output, Busy, OutValid, InReady);
    end
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if ({Output, OutValid, SymEnd, Busy, InReady, Underrun} !== 6'b0) begin
      errors++;
      $display("FAIL tail_async_reset: got %b expected 000000",
               {Output, OutValid, SymEnd, Busy, InReady, Underrun});
    end
    tick;
    Reset = 1'b0;
    tick;
    exp_out = 4'b1101;
    cons = 0;
    start_frame(2'd0);
    for (int k = 0; k < 4; k++) begin
      logic rdy;
      rdy     = InReady;
      InValid = 1'b1;
      InBit   = (cons == 0);
      tick;
      if (rdy) cons++;
      checks++;
      if (Output !== exp_out[3-k]) begin
        errors++;
        $display("FAIL restart_out[%0d]: got %b expected %b", k, Output, exp_out[3-k]);
      end
    end
    InValid = 1'b0;
  endtask

  task automatic test_ignored_controls;
    logic [7:0] exp_out;
    logic [7:0] exp_rdy;
    int         cons;
    exp_out = 8'b11_01_11_11;
    exp_rdy = 8'b10_10_10_10;
    cons = 0;
    apply_reset;
    Flush = 1'b1;
    tick;
    Flush = 1'b0;
    tick;
    checks++;
    if (Busy !== 1'b0 || OutValid !== 1'b0 || InReady !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_idle: got busy=%b ov=%b rdy=%b expected 0 0 0", Busy, OutValid, InReady);
    end
    Rate = 2'd0; Start = 1'b1; Flush = 1'b1;
    tick;
    Start = 1'b0; Flush = 1'b0;
    checks++;
    if (Busy !== 1'b1 || InReady !== 1'b1) begin
      errors++;
      $display("FAIL start_beats_flush: got busy=%b rdy=%b expected 1 1", Busy, InReady);
    end
    for (int k = 0; k < 8; k++) begin
      logic rdy;
      rdy = InReady;
      if (k == 2) begin
        Start = 1'b1;
        Rate  = 2'd2;
      end else begin
        Start = 1'b0;
      end
      InValid = 1'b1;
      InBit   = (cons == 0);
      checks++;
      if (rdy !== exp_rdy[7-k]) begin
        errors++;
        $display("FAIL busy_ready[%0d]: got %b expected %b", k, rdy, exp_rdy[7-k]);
      end
      tick;
      if (rdy) cons++;
      checks++;
      if (Output !== exp_out[7-k] || OutValid !== 1'b1) begin
        errors++;
        $display("FAIL busy_start_out[%0d]: got %b/%b expected %b/1", k, Output, OutValid, exp_out[7-k]);
      end
    end
    Start = 1'b0; InValid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_impulse;
    test_puncture;
    test_framing;
    test_starvation;
    test_reset_mid_tail;
    test_ignored_controls;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
